// File: rtl/cpu_pkg.sv
// Shared constants and loader state encoding for the CPU front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int          ADDR_W = 6;
    localparam int          OP_W   = 16;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam logic [7:0]  HDR    = 8'hA5;
    // Largest legal LEN byte, as a byte so it compares directly with rx_data.
    localparam logic [7:0]  LEN_MAX = 8'(DEPTH);

    typedef enum logic [2:0] {
        LD_IDLE = 3'd0,
        LD_LEN  = 3'd1,
        LD_HI   = 3'd2,
        LD_LO   = 3'd3,
        LD_CSUM = 3'd4,
        LD_RUN  = 3'd5,
        LD_ERR  = 3'd6
    } ld_state_e;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: DEPTH x OP_W, one synchronous write port, one asynchronous read port.
// Latency: write lands on the rising edge; read is combinational from rd_addr.
// Backpressure: none; a write is accepted every cycle wr_en is high.
// Ports: clk; wr_en/wr_addr/wr_dat write port; rd_addr -> rd_dat read port.
module imem_ram
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [OP_W-1:0]   wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [OP_W-1:0]   rd_dat
);

    // Contents are deliberately not reset; readers gate with a valid vector.
    logic [OP_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses HDR/LEN/words/CSUM byte frames into instruction RAM, then serves op=RAM[pc].
// Latency: one byte consumed per transferring cycle; cpu_run rises the cycle after a good CSUM; op is combinational from pc.
// Backpressure: rx_ready is high in every state but RUN; never stalls mid-frame.
// Ports: clk, rst_n (sync, active low); rx_data/rx_valid/rx_ready byte stream; reload pulse;
//        pc -> op instruction read; cpu_run, load_err, word_cnt status.
module imem_loader
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    input  logic [ADDR_W-1:0] pc,
    output logic [OP_W-1:0]   op,
    output logic              cpu_run,
    output logic              load_err,
    output logic [6:0]        word_cnt
);

    ld_state_e          state_q, state_d;
    logic [6:0]         len_q, len_d;
    logic [7:0]         hi_q, hi_d;
    logic [7:0]         csum_q, csum_d;
    logic [6:0]         word_cnt_q, word_cnt_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic               rx_ready_q, rx_ready_d;
    logic               cpu_run_q, cpu_run_d;
    logic               load_err_q, load_err_d;

    logic               xfer;
    logic               ram_we;
    logic [OP_W-1:0]    ram_rd_dat;

    assign xfer = rx_valid & rx_ready_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        hi_d       = hi_q;
        csum_d     = csum_q;
        word_cnt_d = word_cnt_q;
        valid_d    = valid_q;
        ram_we     = 1'b0;

        case (state_q)
            LD_IDLE: begin
                if (xfer && rx_data == HDR) begin
                    state_d = LD_LEN;
                end
            end
            LD_LEN: begin
                if (xfer) begin
                    // A rejected length leaves the previous word_cnt/valid[] untouched.
                    if (rx_data == 8'd0 || rx_data > LEN_MAX) begin
                        state_d = LD_ERR;
                    end else begin
                        len_d      = rx_data[6:0];
                        valid_d    = '0;
                        word_cnt_d = 7'd0;
                        csum_d     = 8'd0;
                        state_d    = LD_HI;
                    end
                end
            end
            LD_HI: begin
                if (xfer) begin
                    hi_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = LD_LO;
                end
            end
            LD_LO: begin
                if (xfer) begin
                    ram_we                            = 1'b1;
                    valid_d[word_cnt_q[ADDR_W-1:0]]   = 1'b1;
                    csum_d                            = csum_q ^ rx_data;
                    word_cnt_d                        = word_cnt_q + 7'd1;
                    state_d = (word_cnt_d == len_q) ? LD_CSUM : LD_HI;
                end
            end
            LD_CSUM: begin
                if (xfer) begin
                    state_d = (rx_data == csum_q) ? LD_RUN : LD_ERR;
                end
            end
            LD_RUN: begin
                // rx_ready is low here, so a concurrent byte is never consumed.
                if (reload) begin
                    state_d = LD_IDLE;
                end
            end
            LD_ERR: begin
                if (reload) begin
                    state_d = LD_IDLE;
                end else if (xfer && rx_data == HDR) begin
                    state_d = LD_LEN;
                end
            end
            default: state_d = LD_IDLE;
        endcase

        // Status outputs are registered off the next state so they track the state flop exactly.
        rx_ready_d = (state_d != LD_RUN);
        cpu_run_d  = (state_d == LD_RUN);
        load_err_d = (state_d == LD_ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= LD_IDLE;
            len_q      <= 7'd0;
            hi_q       <= 8'd0;
            csum_q     <= 8'd0;
            word_cnt_q <= 7'd0;
            valid_q    <= '0;
            rx_ready_q <= 1'b1;
            cpu_run_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            hi_q       <= hi_d;
            csum_q     <= csum_d;
            word_cnt_q <= word_cnt_d;
            valid_q    <= valid_d;
            rx_ready_q <= rx_ready_d;
            cpu_run_q  <= cpu_run_d;
            load_err_q <= load_err_d;
        end
    end

    imem_ram u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (word_cnt_q[ADDR_W-1:0]),
        .wr_dat  ({hi_q, rx_data}),
        .rd_addr (pc),
        .rd_dat  (ram_rd_dat)
    );

    // Unwritten entries and a stopped core both read as zero.
    assign op       = (cpu_run_q && valid_q[pc]) ? ram_rd_dat : '0;
    assign rx_ready = rx_ready_q;
    assign cpu_run  = cpu_run_q;
    assign load_err = load_err_q;
    assign word_cnt = word_cnt_q;

endmodule
